// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: multi-cycle hazard controller for the 5-stage RV32I pipeline.
// Produces per-stage stall/flush controls and E-stage forwarding selects. A
// small interlock FSM inserts LOAD_LAT bubbles per load-use hazard. Two
// saturating counters track stall and redirect cycles.
module hazard_ctrl_mc #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              ICacheMiss,
  input  logic              DCacheMiss,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              JalD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        RegReadD,
  input  logic [1:0]        RegReadE,
  input  logic [2:0]        MemToRegE,
  input  logic [2:0]        RegWriteM,
  input  logic [2:0]        RegWriteW,
  output logic              StallF,
  output logic              FlushF,
  output logic              StallD,
  output logic              FlushD,
  output logic              StallE,
  output logic              FlushE,
  output logic              StallM,
  output logic              FlushM,
  output logic              StallW,
  output logic              FlushW,
  output logic [1:0]        Forward1E,
  output logic [1:0]        Forward2E,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  RedirCnt
);

  typedef enum logic {RUN, LDUSE} state_t;

  // Bubbles still owed after the first one of a load-use sequence.
  localparam logic [1:0] REM_INIT = 2'(LOAD_LAT - 1);

  state_t           state_p0;
  logic [1:0]       rem_p0;
  logic [CNT_W-1:0] stall_cnt_p0;
  logic [CNT_W-1:0] redir_cnt_p0;

  logic luh;
  logic bubble;
  logic redir;
  logic cancel;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return (v == '1) ? v : v + one;
  endfunction

  // M-stage result beats W-stage result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] rs);
    if (used && (RegWriteM != 3'd0) && (RdM != '0) && (RdM == rs)) return 2'b10;
    if (used && (RegWriteW != 3'd0) && (RdW != '0) && (RdW == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign luh = (MemToRegE != 3'd0) && (RdE != '0) &&
               ((RegReadD[1] && (Rs1D == RdE)) || (RegReadD[0] && (Rs2D == RdE)));

  assign Forward1E = fwd_sel(RegReadE[1], Rs1E);
  assign Forward2E = fwd_sel(RegReadE[0], Rs2E);

  assign StallCnt = stall_cnt_p0;
  assign RedirCnt = redir_cnt_p0;

  // Priority arbitration of reset, cache misses, redirects and load-use bubbles.
  always_comb begin
    StallF = 1'b0; FlushF = 1'b0;
    StallD = 1'b0; FlushD = 1'b0;
    StallE = 1'b0; FlushE = 1'b0;
    StallM = 1'b0; FlushM = 1'b0;
    StallW = 1'b0; FlushW = 1'b0;
    bubble = 1'b0;
    redir  = 1'b0;
    cancel = 1'b0;
    if (CPU_RST) begin
      FlushF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
    end else if (DCacheMiss) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1; FlushW = 1'b1;
    end else if (ICacheMiss && (BranchE || JalrE)) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; FlushM = 1'b1;
    end else if (BranchE || JalrE) begin
      FlushD = 1'b1; FlushE = 1'b1;
      redir  = 1'b1;
      cancel = 1'b1;
    end else if (ICacheMiss && JalD) begin
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    end else if (ICacheMiss) begin
      StallF = 1'b1; FlushD = 1'b1;
    end else if (JalD) begin
      FlushD = 1'b1;
      redir  = 1'b1;
    end else if ((state_p0 == LDUSE) || luh) begin
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
      bubble = 1'b1;
    end
  end

  // Interlock state, owed-bubble count and saturating performance counters.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_p0     <= RUN;
      rem_p0       <= 2'd0;
      stall_cnt_p0 <= '0;
      redir_cnt_p0 <= '0;
    end else begin
      if (cancel) begin
        state_p0 <= RUN;
        rem_p0   <= 2'd0;
      end else if (bubble) begin
        if (state_p0 == RUN) begin
          if (LOAD_LAT > 1) begin
            state_p0 <= LDUSE;
            rem_p0   <= REM_INIT;
          end
        end else if (rem_p0 == 2'd1) begin
          state_p0 <= RUN;
          rem_p0   <= 2'd0;
        end else begin
          rem_p0 <= rem_p0 - 2'd1;
        end
      end
      if (StallF) stall_cnt_p0 <= sat_inc(stall_cnt_p0);
      if (redir)  redir_cnt_p0 <= sat_inc(redir_cnt_p0);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: three instances with different LOAD_LAT/CNT_W
// share one stimulus stream and are compared against a priority-rule model.
module tb_hazard_ctrl_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, imiss, dmiss, br, jalr, jald;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0] rrd, rre;
  logic [2:0] m2r, rwm, rww;

  // ctl bits: 9 StallF 8 FlushF 7 StallD 6 FlushD 5 StallE 4 FlushE
  //           3 StallM 2 FlushM 1 StallW 0 FlushW
  wire [9:0]  ctl_a, ctl_b, ctl_c;
  wire [1:0]  f1_a, f2_a, f1_b, f2_b, f1_c, f2_c;
  wire [15:0] sc_a, rc_a, sc_c, rc_c;
  wire [3:0]  sc_b, rc_b;

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u_a (
    .CPU_CLK(clk), .CPU_RST(rst), .ICacheMiss(imiss), .DCacheMiss(dmiss),
    .BranchE(br), .JalrE(jalr), .JalD(jald),
    .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
    .RegReadD(rrd), .RegReadE(rre), .MemToRegE(m2r), .RegWriteM(rwm), .RegWriteW(rww),
    .StallF(ctl_a[9]), .FlushF(ctl_a[8]), .StallD(ctl_a[7]), .FlushD(ctl_a[6]),
    .StallE(ctl_a[5]), .FlushE(ctl_a[4]), .StallM(ctl_a[3]), .FlushM(ctl_a[2]),
    .StallW(ctl_a[1]), .FlushW(ctl_a[0]),
    .Forward1E(f1_a), .Forward2E(f2_a), .StallCnt(sc_a), .RedirCnt(rc_a));

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_b (
    .CPU_CLK(clk), .CPU_RST(rst), .ICacheMiss(imiss), .DCacheMiss(dmiss),
    .BranchE(br), .JalrE(jalr), .JalD(jald),
    .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
    .RegReadD(rrd), .RegReadE(rre), .MemToRegE(m2r), .RegWriteM(rwm), .RegWriteW(rww),
    .StallF(ctl_b[9]), .FlushF(ctl_b[8]), .StallD(ctl_b[7]), .FlushD(ctl_b[6]),
    .StallE(ctl_b[5]), .FlushE(ctl_b[4]), .StallM(ctl_b[3]), .FlushM(ctl_b[2]),
    .StallW(ctl_b[1]), .FlushW(ctl_b[0]),
    .Forward1E(f1_b), .Forward2E(f2_b), .StallCnt(sc_b), .RedirCnt(rc_b));

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_c (
    .CPU_CLK(clk), .CPU_RST(rst), .ICacheMiss(imiss), .DCacheMiss(dmiss),
    .BranchE(br), .JalrE(jalr), .JalD(jald),
    .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
    .RegReadD(rrd), .RegReadE(rre), .MemToRegE(m2r), .RegWriteM(rwm), .RegWriteW(rww),
    .StallF(ctl_c[9]), .FlushF(ctl_c[8]), .StallD(ctl_c[7]), .FlushD(ctl_c[6]),
    .StallE(ctl_c[5]), .FlushE(ctl_c[4]), .StallM(ctl_c[3]), .FlushM(ctl_c[2]),
    .StallW(ctl_c[1]), .FlushW(ctl_c[0]),
    .Forward1E(f1_c), .Forward2E(f2_c), .StallCnt(sc_c), .RedirCnt(rc_c));

  typedef struct packed {
    logic       imiss, dmiss, br, jalr, jald;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rrd, rre;
    logic [2:0] m2r, rwm, rww;
  } in_t;

  typedef struct {
    in_t        i;
    logic [9:0] ctl;
    logic [1:0] f1, f2;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, bubbles still owed and counter values.
  int  owed [3];
  int  scnt [3];
  int  rcnt [3];
  int  ll   [3];
  int  cmax [3];
  bit  known;
  logic [9:0] ctl_tab [1:9];
  vec_t tv [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t x;
    x = '0;
    return x;
  endfunction

  task automatic apply(input in_t x);
    imiss = x.imiss; dmiss = x.dmiss; br = x.br; jalr = x.jalr; jald = x.jald;
    rs1d = x.rs1d; rs2d = x.rs2d; rs1e = x.rs1e; rs2e = x.rs2e;
    rde = x.rde; rdm = x.rdm; rdw = x.rdw;
    rrd = x.rrd; rre = x.rre; m2r = x.m2r; rwm = x.rwm; rww = x.rww;
  endtask

  function automatic logic [9:0] get_ctl(int k);
    case (k)
      0: return ctl_a;
      1: return ctl_b;
      default: return ctl_c;
    endcase
  endfunction

  function automatic logic [3:0] get_fwd(int k);
    case (k)
      0: return {f1_a, f2_a};
      1: return {f1_b, f2_b};
      default: return {f1_c, f2_c};
    endcase
  endfunction

  function automatic logic [31:0] get_sc(int k);
    case (k)
      0: return 32'(sc_a);
      1: return 32'(sc_b);
      default: return 32'(sc_c);
    endcase
  endfunction

  function automatic logic [31:0] get_rc(int k);
    case (k)
      0: return 32'(rc_a);
      1: return 32'(rc_b);
      default: return 32'(rc_c);
    endcase
  endfunction

  function automatic bit luh_m();
    return (m2r != 0) && (rde != 0) &&
           ((rrd[1] && rs1d == rde) || (rrd[0] && rs2d == rde));
  endfunction

  // Which numbered priority rule wins this cycle for instance k.
  function automatic int winner(int k);
    if (rst)                    return 1;
    if (dmiss)                  return 2;
    if (imiss && (br || jalr))  return 3;
    if (br || jalr)             return 4;
    if (imiss && jald)          return 5;
    if (imiss)                  return 6;
    if (jald)                   return 7;
    if (owed[k] > 0 || luh_m()) return 8;
    return 9;
  endfunction

  function automatic logic [1:0] fwd_m(input logic used, input logic [4:0] rs);
    if (used && rwm != 0 && rdm != 0 && rdm == rs) return 2'b10;
    if (used && rww != 0 && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Check all instances against the model for the current inputs, then clock.
  task automatic do_cycle();
    int w;
    logic [9:0] ec;
    #1;
    for (int k = 0; k < 3; k++) begin
      w  = winner(k);
      ec = ctl_tab[w];
      chk($sformatf("ctl[%0d]", k), 32'(get_ctl(k)), 32'(ec));
      chk($sformatf("fwd[%0d]", k), 32'(get_fwd(k)),
          32'({fwd_m(rre[1], rs1e), fwd_m(rre[0], rs2e)}));
      if (known) begin
        chk($sformatf("stallcnt[%0d]", k), get_sc(k), 32'(scnt[k]));
        chk($sformatf("redircnt[%0d]", k), get_rc(k), 32'(rcnt[k]));
      end
      if (w == 1) begin
        owed[k] = 0; scnt[k] = 0; rcnt[k] = 0;
      end else begin
        if (w == 4) owed[k] = 0;
        if (w == 8) owed[k] = (owed[k] == 0) ? ll[k] - 1 : owed[k] - 1;
        if (ec[9] && scnt[k] < cmax[k]) scnt[k]++;
        if ((w == 4 || w == 7) && rcnt[k] < cmax[k]) rcnt[k]++;
      end
    end
    if (rst) known = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(idle());
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
  endtask

  function automatic in_t luh_in();
    in_t x;
    x = idle();
    x.m2r = 3'd1; x.rde = 5'd5; x.rrd = 2'b10; x.rs1d = 5'd5;
    return x;
  endfunction

  initial begin
    in_t x;
    ll   = '{2, 3, 1};
    cmax = '{65535, 15, 65535};
    owed = '{0, 0, 0};
    scnt = '{0, 0, 0};
    rcnt = '{0, 0, 0};
    known = 1'b0;
    ctl_tab[1] = 10'b0101010101;
    ctl_tab[2] = 10'b1010101001;
    ctl_tab[3] = 10'b1010100100;
    ctl_tab[4] = 10'b0001010000;
    ctl_tab[5] = 10'b1010010000;
    ctl_tab[6] = 10'b1001000000;
    ctl_tab[7] = 10'b0001000000;
    ctl_tab[8] = 10'b1010010000;
    ctl_tab[9] = 10'b0000000000;

    // Table of single-cycle vectors applied from the RUN state.
    for (int k = 0; k < 13; k++) begin
      tv[k].i = idle(); tv[k].ctl = 10'b0; tv[k].f1 = 2'b00; tv[k].f2 = 2'b00;
    end
    tv[1].i.dmiss = 1'b1; tv[1].i.br = 1'b1;   tv[1].ctl = 10'b1010101001;
    tv[2].i.imiss = 1'b1; tv[2].i.jalr = 1'b1; tv[2].ctl = 10'b1010100100;
    tv[3].i.br = 1'b1;                         tv[3].ctl = 10'b0001010000;
    tv[4].i.imiss = 1'b1; tv[4].i.jald = 1'b1; tv[4].ctl = 10'b1010010000;
    tv[5].i.imiss = 1'b1;                      tv[5].ctl = 10'b1001000000;
    tv[6].i.jald = 1'b1;                       tv[6].ctl = 10'b0001000000;
    tv[7].i.rdm = 5'd7; tv[7].i.rdw = 5'd7; tv[7].i.rwm = 3'd1; tv[7].i.rww = 3'd1;
    tv[7].i.rs2e = 5'd7; tv[7].i.rre = 2'b01; tv[7].f2 = 2'b10;
    tv[8].i.rwm = 3'd1; tv[8].i.rww = 3'd1; tv[8].i.rre = 2'b11;
    tv[9].i.rs1e = 5'd3; tv[9].i.rdw = 5'd3; tv[9].i.rww = 3'd2; tv[9].i.rdm = 5'd4;
    tv[9].i.rwm = 3'd1; tv[9].i.rre = 2'b10; tv[9].f1 = 2'b01;
    tv[10].i.rs1e = 5'd3; tv[10].i.rdm = 5'd3; tv[10].i.rwm = 3'd1; tv[10].i.rre = 2'b01;
    tv[11].i.rs2e = 5'd9; tv[11].i.rdm = 5'd9; tv[11].i.rdw = 5'd9; tv[11].i.rww = 3'd4;
    tv[11].i.rre = 2'b01; tv[11].f2 = 2'b01;
    tv[12].i.jalr = 1'b1;                      tv[12].ctl = 10'b0001010000;

    apply(idle());
    rst = 1'b0;

    // Reset dominates a pending D-miss.
    x = idle(); x.dmiss = 1'b1; apply(x); rst = 1'b1;
    #1 chk("reset_ctl", 32'(ctl_a), 32'(10'b0101010101));
    do_cycle();
    apply(idle());
    do_cycle();
    rst = 1'b0;
    #1 chk("post_reset_ctl", 32'(ctl_a), 32'd0);
    chk("post_reset_stallcnt", 32'(sc_a), 32'd0);
    chk("post_reset_redircnt", 32'(rc_a), 32'd0);
    do_cycle();

    // Table-driven vectors.
    for (int k = 0; k < 13; k++) begin
      apply(tv[k].i);
      #1;
      chk($sformatf("vec%0d_ctl", k), 32'(ctl_a), 32'(tv[k].ctl));
      chk($sformatf("vec%0d_f1", k), 32'(f1_a), 32'(tv[k].f1));
      chk($sformatf("vec%0d_f2", k), 32'(f2_a), 32'(tv[k].f2));
      do_cycle();
    end

    // Load-use with LOAD_LAT = 2 followed by W forwarding to the dependent op.
    do_reset();
    apply(luh_in());
    #1 chk("lu_c0", 32'(ctl_a), 32'(10'b1010010000));
    do_cycle();
    x = idle(); x.rdm = 5'd5; x.rwm = 3'd1; x.rs1d = 5'd5; x.rrd = 2'b10; apply(x);
    #1 chk("lu_c1", 32'(ctl_a), 32'(10'b1010010000));
    chk("lu_c1_lat1", 32'(ctl_c), 32'd0);
    do_cycle();
    x = idle(); x.rdw = 5'd5; x.rww = 3'd1; x.rs1e = 5'd5; x.rre = 2'b10; apply(x);
    #1 chk("lu_c2", 32'(ctl_a), 32'd0);
    chk("lu_fwd_w", 32'(f1_a), 32'(2'b01));
    chk("lu_c2_lat3", 32'(ctl_b[9]), 32'd1);
    do_cycle();
    apply(idle());
    #1 chk("lu_stallcnt", 32'(sc_a), 32'd2);
    do_cycle();

    // Branch cancels an LOAD_LAT = 3 interlock after the first bubble.
    do_reset();
    apply(luh_in());
    do_cycle();
    x = idle(); x.br = 1'b1; apply(x);
    #1 chk("br_cancel_ctl", 32'(ctl_b), 32'(10'b0001010000));
    do_cycle();
    apply(idle());
    #1 chk("br_no_third_bubble", 32'(ctl_b), 32'd0);
    do_cycle();
    #1 chk("br_redircnt", 32'(rc_b), 32'd1);
    chk("br_stallcnt", 32'(sc_b), 32'd1);
    do_cycle();

    // D-miss for four cycles inside LDUSE freezes the owed bubbles.
    do_reset();
    apply(luh_in());
    do_cycle();
    for (int c = 0; c < 4; c++) begin
      x = idle(); x.dmiss = 1'b1; apply(x);
      do_cycle();
    end
    apply(idle());
    #1 chk("dm_resume1", 32'(ctl_b[9]), 32'd1);
    chk("dm_resume_a", 32'(ctl_a[9]), 32'd1);
    do_cycle();
    #1 chk("dm_resume2", 32'(ctl_b[9]), 32'd1);
    chk("dm_done_a", 32'(ctl_a[9]), 32'd0);
    do_cycle();
    #1 chk("dm_done_b", 32'(ctl_b[9]), 32'd0);
    chk("dm_stallcnt", 32'(sc_b), 32'd7);
    do_cycle();

    // Saturation: 4-bit counter sticks at 15 under a long I-miss.
    do_reset();
    x = idle(); x.imiss = 1'b1; apply(x);
    for (int c = 0; c < 20; c++) do_cycle();
    #1 chk("sat_b", 32'(sc_b), 32'd15);
    chk("sat_a", 32'(sc_a), 32'd20);
    do_cycle();
    #1 chk("sat_b_hold", 32'(sc_b), 32'd15);
    do_cycle();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      x = idle();
      x.imiss = ($urandom_range(0, 5) == 0);
      x.dmiss = ($urandom_range(0, 7) == 0);
      x.br    = ($urandom_range(0, 9) == 0);
      x.jalr  = ($urandom_range(0, 14) == 0);
      x.jald  = ($urandom_range(0, 9) == 0);
      x.rs1d  = 5'($urandom_range(0, 3));
      x.rs2d  = 5'($urandom_range(0, 3));
      x.rs1e  = 5'($urandom_range(0, 3));
      x.rs2e  = 5'($urandom_range(0, 3));
      x.rde   = 5'($urandom_range(0, 3));
      x.rdm   = 5'($urandom_range(0, 3));
      x.rdw   = 5'($urandom_range(0, 3));
      x.rrd   = 2'($urandom_range(0, 3));
      x.rre   = 2'($urandom_range(0, 3));
      x.m2r   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      x.rwm   = 3'($urandom_range(0, 2));
      x.rww   = 3'($urandom_range(0, 2));
      apply(x);
      rst = ($urandom_range(0, 59) == 0);
      do_cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised multi-cycle hazard controller for the 5-stage RV32I pipeline, replacing the purely combinational hazard unit. It generates per-stage stall/flush and E-stage forwarding selects. It adds a load-use interlock FSM with a configurable bubble count, priority arbitration between cache misses and control redirects, and saturating performance counters. It sits beside the pipeline registers in the CPU core and is clocked with them.

## Interface

Parameters:
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, bubbles inserted per load-use hazard; legal range 1..3.
- CNT_W, 16, width of each performance counter.

Ports:
- CPU_CLK  in  1  core clock; all state updates on the rising edge.
- CPU_RST  in  1  synchronous, active-high reset.
- ICacheMiss, DCacheMiss  in  1  cache miss pending, level-sensitive.
- BranchE, JalrE, JalD  in  1  taken branch / jalr in E; jal in D.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW  register numbers.
- RegReadD, RegReadE  in  2  bit1: rs1 used; bit0: rs2 used.
- MemToRegE  in  3  non-zero means a load is in E.
- RegWriteM, RegWriteW  in  3  non-zero means a register write.
- StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1  pipeline register controls.
- Forward1E, Forward2E  out  2  00 = regfile, 10 = from M, 01 = from W.
- StallCnt, RedirCnt  out  CNT_W  performance counters.

## Operation

- State register: RUN, LDUSE. A bubble counter `rem` (2 bits) holds the bubbles still owed.
- Outputs are combinational from the current state and inputs. Only the state, `rem` and the counters are registered.
- Load-use hazard (luh) is asserted when all of the following hold:
  - MemToRegE != 0 and RdE != 0;
  - (RegReadD[1] and Rs1D == RdE) or (RegReadD[0] and Rs2D == RdE).
- Per-cycle priority, highest first:
  1. CPU_RST: all Flush* = 1, all Stall* = 0, state goes to RUN, rem = 0, both counters = 0.
  2. DCacheMiss: StallF, StallD, StallE and StallM = 1; FlushW = 1. The state and rem are held.
  3. ICacheMiss with BranchE or JalrE: redirect deferred. StallF, StallD and StallE = 1; FlushM = 1.
  4. BranchE or JalrE: FlushD and FlushE = 1. Any load-use sequence is cancelled (state goes to RUN, rem = 0).
  5. ICacheMiss with JalD: StallF and StallD = 1; FlushE = 1.
  6. ICacheMiss: StallF = 1; FlushD = 1.
  7. JalD: FlushD = 1.
  8. Load-use bubble, when state == LDUSE or (RUN and luh): StallF and StallD = 1; FlushE = 1.
     - From RUN: if LOAD_LAT > 1, go to LDUSE with rem = LOAD_LAT - 1.
     - In LDUSE: rem decrements each bubble. The bubble with rem == 1 is the last one; the state then returns to RUN.
  9. Otherwise all controls are 0.
- FlushF is asserted only during reset.
- Forwarding for source n (shown for rs1; rs2 is identical using Rs2E and RegReadE[0]):
  - 10 if RegReadE[1], RegWriteM != 0, RdM != 0 and RdM == Rs1E;
  - else 01 if RegReadE[1], RegWriteW != 0, RdW != 0 and RdW == Rs1E;
  - else 00.
  - M beats W. Register x0 is never forwarded. Forwarding is evaluated regardless of stalls.
- StallCnt: +1 on each cycle with StallF = 1.
- RedirCnt: +1 on each cycle where priority 4 or 7 wins.
- Both counters saturate at 2^CNT_W - 1 and do not wrap.

## Timing

- Zero-cycle latency from inputs to stall, flush and forward outputs.
- A load-use hazard costs exactly LOAD_LAT cycles with StallF = 1, excluding any cycles frozen by a D-miss.
- A D-miss during LDUSE freezes rem. The remaining bubbles resume when the miss drops.
- Counters update on the edge after the counted cycle.
- CPU_RST asserted mid-sequence overrides everything. On the first post-reset edge the state is RUN and the counters are 0.
- Reset values: state RUN, rem 0, StallCnt 0, RedirCnt 0.

## Test plan

- Reset:
  - Drive CPU_RST = 1 with DCacheMiss = 1 -> all Flush* = 1 and all Stall* = 0.
  - Release reset -> StallCnt = RedirCnt = 0 and all outputs are 0 with idle inputs.
- Load-use, LOAD_LAT = 2:
  - Stimulus: load RdE = 5, MemToRegE = 1; RegReadD = 10 with Rs1D = 5.
  - Required: two consecutive cycles of StallF/StallD/FlushE, then RUN; StallCnt = 2.
  - On the dependent instruction in E with RdW = 5 -> Forward1E = 01.
- Forward priority:
  - RdM = RdW = 7, both writing, Rs2E = 7, RegReadE = 01 -> Forward2E = 10.
  - Rs2E = 0 with RdM = 0 -> Forward2E = 00.
- Branch cancels interlock:
  - LOAD_LAT = 3, luh in cycle 0, BranchE = 1 in cycle 1.
  - Required: FlushD/FlushE in cycle 1, state RUN, RedirCnt = 1, no third bubble.
- Miss arbitration:
  - DCacheMiss with BranchE -> StallE = 1, FlushW = 1, FlushE = 0.
  - ICacheMiss with JalrE -> StallF/StallD/StallE = 1, FlushM = 1.
  - D-miss for 4 cycles inside LDUSE -> rem held, bubbles resume afterwards.
- Saturation:
  - CNT_W = 4, hold ICacheMiss for 20 cycles -> StallCnt = 15 and stays at 15.
